// File: rtl/bsg_axil_shell_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_axil_shell_pkg
// Description : Shared constants for the AXI4-Lite CSR/FIFO shell. Holds the
//               address-region bases, the AXI response codes and the
//               transaction FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_axil_shell_pkg;

    // Region bases within the 1 KiB window. Only bits [9:8] pick the region.
    localparam logic [9:0] c_csr_base   = 10'h000;
    localparam logic [9:0] c_ps2pl_base = 10'h100;
    localparam logic [9:0] c_pl2ps_base = 10'h200;
    localparam logic [9:0] c_occ_base   = 10'h300;

    localparam logic [1:0] c_region_csr   = c_csr_base[9:8];
    localparam logic [1:0] c_region_ps2pl = c_ps2pl_base[9:8];
    localparam logic [1:0] c_region_pl2ps = c_pl2ps_base[9:8];
    localparam logic [1:0] c_region_occ   = c_occ_base[9:8];

    // AXI response codes
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRESP = 2'd1,
        ST_RRESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_axil_shell_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bsg_axil_shell_fifo
// Description : Single-clock 1r1w word FIFO. Ready/valid on the enqueue side,
//               valid/yumi on the dequeue side, plus an occupancy count.
//               Enqueue and dequeue in the same cycle both take effect.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               enq_data/enq_v  - word to enqueue and its request
//               enq_ready       - not full
//               deq_data/deq_v  - head word and head valid
//               deq_yumi        - consume head (only while deq_v)
//               count           - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_axil_shell_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       enq_v,
    output logic                       enq_ready,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       deq_v,
    input  logic                       deq_yumi,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_enq;
    logic             w_deq;

    assign enq_ready = (r_count != c_depth);
    assign deq_v     = (r_count != '0);
    assign deq_data  = r_mem[r_rptr];
    assign count     = r_count;

    assign w_enq = enq_v & enq_ready;
    assign w_deq = deq_yumi & deq_v;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + c_ptr_one;
            if (w_deq) r_rptr <= r_rptr + c_ptr_one;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wptr] <= enq_data;
    end

endmodule
`default_nettype wire

// File: rtl/bsg_axil_csr_fifo_shell.sv
`default_nettype none
// ============================================================================
// Module      : bsg_axil_csr_fifo_shell
// Description : AXI4-Lite slave shell exposing NUM_CSR control registers,
//               NUM_PS2PL host->fabric FIFOs and NUM_PL2PS fabric->host FIFOs.
//               One transaction in flight; fair write/read arbitration.
// Ports       : aclk, areset           - clock, synchronous active-high reset
//               s00_axi_*              - AXI4-Lite slave (prot ignored)
//               csr_data_o             - CSR i at [32i+:32]
//               ps2pl_data_o/v_o/yumi_i - PS->PL FIFO heads, PL consumes
//               pl2ps_data_i/v_i/ready_o - PL->PS FIFO enqueue
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_axil_csr_fifo_shell
    import bsg_axil_shell_pkg::*;
#(
    parameter int C_GP0_AXI_ADDR_WIDTH = 10,
    parameter int C_GP0_AXI_DATA_WIDTH = 32,
    parameter int NUM_CSR              = 4,
    parameter int NUM_PS2PL            = 1,
    parameter int NUM_PL2PS            = 1,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                              aclk,
    input  logic                              areset,

    input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_GP0_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_GP0_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_GP0_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_GP0_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,

    output logic [NUM_CSR*32-1:0]             csr_data_o,
    output logic [NUM_PS2PL*32-1:0]           ps2pl_data_o,
    output logic [NUM_PS2PL-1:0]              ps2pl_v_o,
    input  logic [NUM_PS2PL-1:0]              ps2pl_yumi_i,
    input  logic [NUM_PL2PS*32-1:0]           pl2ps_data_i,
    input  logic [NUM_PL2PS-1:0]              pl2ps_v_i,
    output logic [NUM_PL2PS-1:0]              pl2ps_ready_o
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [6:0]         c_num_csr   = 7'(NUM_CSR);
    localparam logic [6:0]         c_num_ps2pl = 7'(NUM_PS2PL);
    localparam logic [6:0]         c_num_pl2ps = 7'(NUM_PL2PS);

    // Address slots are always 64 wide so a 6-bit index never exceeds an
    // array; slots beyond the configured counts are constant tie-offs.
    logic [31:0]        r_csr [64];
    logic [c_cnt_w-1:0] w_ps2pl_count [64];
    logic               w_ps2pl_ready [64];
    logic [c_cnt_w-1:0] w_pl2ps_count [64];
    logic               w_pl2ps_v     [64];
    logic [31:0]        w_pl2ps_head  [64];

    logic [63:0]        w_csr_we;
    logic [63:0]        w_push;
    logic [63:0]        w_pop;

    state_e             r_state;
    state_e             w_state_n;
    logic               r_prio_wr;
    logic               w_wr_elig;
    logic               w_rd_elig;
    logic               w_grant_wr;
    logic               w_grant_rd;
    logic               w_wr_go;
    logic               w_rd_go;

    logic [1:0]         w_wr_region;
    logic [5:0]         w_wr_idx;
    logic [1:0]         w_rd_region;
    logic [5:0]         w_rd_idx;
    logic [1:0]         w_wr_resp;
    logic [1:0]         w_rd_resp;
    logic [31:0]        w_rd_data;
    logic [c_cnt_w-1:0] w_free;

    logic [1:0]         r_bresp;
    logic [1:0]         r_rresp;
    logic [31:0]        r_rdata;
    logic               w_unused_ok;

    // Only bits [9:8] (region) and [7:2] (word index) are decoded.
    assign w_wr_region = s00_axi_awaddr[9:8];
    assign w_wr_idx    = s00_axi_awaddr[7:2];
    assign w_rd_region = s00_axi_araddr[9:8];
    assign w_rd_idx    = s00_axi_araddr[7:2];

    // ------------------------------------------------------------------
    // Arbitration and transaction FSM
    // ------------------------------------------------------------------
    assign w_wr_elig  = s00_axi_awvalid & s00_axi_wvalid;
    assign w_rd_elig  = s00_axi_arvalid;
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | r_prio_wr);
    assign w_grant_rd = w_rd_elig & ~w_grant_wr;

    always_comb begin
        w_state_n = r_state;
        w_wr_go   = 1'b0;
        w_rd_go   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Holding off during reset keeps a new transaction from
                // being accepted and then discarded.
                if (!areset) begin
                    if (w_grant_wr) begin
                        w_wr_go   = 1'b1;
                        w_state_n = ST_WRESP;
                    end else if (w_grant_rd) begin
                        w_rd_go   = 1'b1;
                        w_state_n = ST_RRESP;
                    end
                end
            end
            ST_WRESP: if (s00_axi_bready) w_state_n = ST_IDLE;
            ST_RRESP: if (s00_axi_rready) w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_n;
    end

    // Priority flips only when both sides competed; the loser goes first
    // next time.
    always_ff @(posedge aclk) begin
        if (areset)
            r_prio_wr <= 1'b1;
        else if (w_wr_elig && w_rd_elig && (w_wr_go || w_rd_go))
            r_prio_wr <= w_rd_go;
    end

    assign s00_axi_awready = w_wr_go;
    assign s00_axi_wready  = w_wr_go;
    assign s00_axi_arready = w_rd_go;
    assign s00_axi_bvalid  = (r_state == ST_WRESP);
    assign s00_axi_rvalid  = (r_state == ST_RRESP);
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;

    // ------------------------------------------------------------------
    // Write decode: full/empty come from cycle-start FIFO state
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_resp = c_resp_okay;
        w_csr_we  = '0;
        w_push    = '0;
        case (w_wr_region)
            c_region_csr: begin
                if ({1'b0, w_wr_idx} < c_num_csr) w_csr_we[w_wr_idx] = w_wr_go;
                else                              w_wr_resp = c_resp_decerr;
            end
            c_region_ps2pl: begin
                if ({1'b0, w_wr_idx} < c_num_ps2pl) begin
                    if (w_ps2pl_ready[w_wr_idx]) w_push[w_wr_idx] = w_wr_go;
                    else                         w_wr_resp = c_resp_slverr;
                end else begin
                    w_wr_resp = c_resp_decerr;
                end
            end
            default: begin
                // Pop and occupancy regions are read-only.
                if ({1'b0, w_wr_idx} < c_num_pl2ps) w_wr_resp = c_resp_slverr;
                else                                w_wr_resp = c_resp_decerr;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    assign w_free = c_depth - w_ps2pl_count[w_rd_idx];

    always_comb begin
        w_rd_resp = c_resp_okay;
        w_rd_data = '0;
        w_pop     = '0;
        case (w_rd_region)
            c_region_csr: begin
                if ({1'b0, w_rd_idx} < c_num_csr) w_rd_data = r_csr[w_rd_idx];
                else                              w_rd_resp = c_resp_decerr;
            end
            c_region_ps2pl: begin
                if ({1'b0, w_rd_idx} < c_num_ps2pl)
                    w_rd_data = {{(32-c_cnt_w){1'b0}}, w_free};
                else
                    w_rd_resp = c_resp_decerr;
            end
            c_region_pl2ps: begin
                if ({1'b0, w_rd_idx} < c_num_pl2ps) begin
                    if (w_pl2ps_v[w_rd_idx]) begin
                        w_rd_data         = w_pl2ps_head[w_rd_idx];
                        w_pop[w_rd_idx]   = w_rd_go;
                    end else begin
                        w_rd_resp = c_resp_slverr;
                    end
                end else begin
                    w_rd_resp = c_resp_decerr;
                end
            end
            default: begin
                if ({1'b0, w_rd_idx} < c_num_pl2ps)
                    w_rd_data = {{(32-c_cnt_w){1'b0}}, w_pl2ps_count[w_rd_idx]};
                else
                    w_rd_resp = c_resp_decerr;
            end
        endcase
    end

    // Response registers: captured at accept, held through the response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_bresp <= c_resp_okay;
            r_rresp <= c_resp_okay;
            r_rdata <= '0;
        end else begin
            if (w_wr_go) r_bresp <= w_wr_resp;
            if (w_rd_go) begin
                r_rresp <= w_rd_resp;
                r_rdata <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers with per-byte strobes
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 64; i++) r_csr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CSR; i++) begin
                if (w_csr_we[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s00_axi_wstrb[b]) r_csr[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CSR; i++) begin : g_csr_out
            assign csr_data_o[32*i +: 32] = r_csr[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO instances
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 64; i++) begin : g_ps2pl
            if (i < NUM_PS2PL) begin : g_fifo
                bsg_axil_shell_fifo #(
                    .DEPTH (FIFO_DEPTH),
                    .WIDTH (32)
                ) u_fifo (
                    .clk       (aclk),
                    .reset     (areset),
                    .enq_data  (s00_axi_wdata),
                    .enq_v     (w_push[i]),
                    .enq_ready (w_ps2pl_ready[i]),
                    .deq_data  (ps2pl_data_o[32*i +: 32]),
                    .deq_v     (ps2pl_v_o[i]),
                    .deq_yumi  (ps2pl_yumi_i[i]),
                    .count     (w_ps2pl_count[i])
                );
            end else begin : g_none
                assign w_ps2pl_ready[i] = 1'b0;
                assign w_ps2pl_count[i] = '0;
            end
        end

        for (genvar i = 0; i < 64; i++) begin : g_pl2ps
            if (i < NUM_PL2PS) begin : g_fifo
                logic w_enq_ready;

                bsg_axil_shell_fifo #(
                    .DEPTH (FIFO_DEPTH),
                    .WIDTH (32)
                ) u_fifo (
                    .clk       (aclk),
                    .reset     (areset),
                    .enq_data  (pl2ps_data_i[32*i +: 32]),
                    .enq_v     (pl2ps_v_i[i]),
                    .enq_ready (w_enq_ready),
                    .deq_data  (w_pl2ps_head[i]),
                    .deq_v     (w_pl2ps_v[i]),
                    .deq_yumi  (w_pop[i]),
                    .count     (w_pl2ps_count[i])
                );

                // Held low while in reset, high from the first cycle after.
                assign pl2ps_ready_o[i] = w_enq_ready & ~areset;
            end else begin : g_none
                assign w_pl2ps_head[i]  = '0;
                assign w_pl2ps_v[i]     = 1'b0;
                assign w_pl2ps_count[i] = '0;
            end
        end
    endgenerate

    // Inputs and decode bits with no functional use in this configuration.
    assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr,
                           s00_axi_araddr, w_csr_we, w_push, w_pop};

endmodule
`default_nettype wire

// File: tb/tb_bsg_axil_csr_fifo_shell.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_axil_csr_fifo_shell
// Description : Directed self-checking bench for bsg_axil_csr_fifo_shell with
//               default parameters (4 CSRs, one FIFO each way, depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_axil_csr_fifo_shell;

    logic         aclk = 1'b0;
    logic         areset;
    logic [9:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [9:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] csr_data;
    logic [31:0]  ps2pl_data;
    logic [0:0]   ps2pl_v;
    logic [0:0]   ps2pl_yumi;
    logic [31:0]  pl2ps_data;
    logic [0:0]   pl2ps_v;
    logic [0:0]   pl2ps_ready;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    bsg_axil_csr_fifo_shell dut (
        .aclk            (aclk),
        .areset          (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .csr_data_o      (csr_data),
        .ps2pl_data_o    (ps2pl_data),
        .ps2pl_v_o       (ps2pl_v),
        .ps2pl_yumi_i    (ps2pl_yumi),
        .pl2ps_data_i    (pl2ps_data),
        .pl2ps_v_i       (pl2ps_v),
        .pl2ps_ready_o   (pl2ps_ready)
    );

    // Bus driver: aligns to just after a rising edge, waits for the accept,
    // then collects the response.
    task automatic axi_write(input logic [9:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit ok;
        ok   = 1'b0;
        resp = 2'bxx;
        @(posedge aclk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge aclk);
                if (bvalid) begin ok = 1'b1; resp = bresp; break; end
            end
            @(posedge aclk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL write_timeout addr=%h: no handshake within budget", a);
        end
    endtask

    task automatic axi_read(input logic [9:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit ok;
        ok   = 1'b0;
        d    = 'x;
        resp = 2'bxx;
        @(posedge aclk); #1;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge aclk);
                if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; break; end
            end
            @(posedge aclk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL read_timeout addr=%h: no handshake within budget", a);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; araddr = '0; arprot = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1;
        ps2pl_yumi = '0; pl2ps_data = '0; pl2ps_v = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b exp=0", awready); end
        checks++; if (arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b exp=0", arready); end
        checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL reset_valids got b=%b r=%b exp 0 0", bvalid, rvalid); end
        checks++; if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin failures++; $display("FAIL reset_resp got rdata=%h bresp=%b rresp=%b exp 0", rdata, bresp, rresp); end
        checks++; if (csr_data !== 128'h0) begin failures++; $display("FAIL reset_csr got=%h exp=0", csr_data); end
        checks++; if (ps2pl_v !== 1'b0) begin failures++; $display("FAIL reset_ps2pl_v got=%b exp=0", ps2pl_v); end
        checks++; if (pl2ps_ready !== 1'b0) begin failures++; $display("FAIL reset_pl2ps_ready_in_reset got=%b exp=0", pl2ps_ready); end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++; if (pl2ps_ready !== 1'b1) begin failures++; $display("FAIL reset_pl2ps_ready_after got=%b exp=1", pl2ps_ready); end
    endtask

    task automatic test_csr_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(10'h004, 32'hDEADBEEF, 4'b0011, r);
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL csr_wr_resp got=%b exp=00", r); end
        checks++; if (csr_data[63:32] !== 32'h0000BEEF) begin failures++; $display("FAIL csr1_value got=%h exp=0000beef", csr_data[63:32]); end
        axi_read(10'h004, d, r);
        checks++; if (d !== 32'h0000BEEF || r !== 2'b00) begin failures++; $display("FAIL csr1_read got=%h/%b exp=0000beef/00", d, r); end
        axi_write(10'h000, 32'h12345678, 4'b1111, r);
        axi_write(10'h000, 32'hAABBCCDD, 4'b1100, r);
        checks++; if (csr_data[31:0] !== 32'hAABB5678) begin failures++; $display("FAIL csr0_upper_strobe got=%h exp=aabb5678", csr_data[31:0]); end
    endtask

    task automatic test_ps2pl_fill();
        logic [1:0]  r;
        logic [31:0] d;
        axi_read(10'h100, d, r);
        checks++; if (d !== 32'd8 || r !== 2'b00) begin failures++; $display("FAIL ps2pl_free_empty got=%0d/%b exp=8/00", d, r); end
        for (int k = 0; k < 9; k++) begin
            axi_write(10'h100, 32'hA0 + k, 4'b0000, r);
            checks++;
            if (r !== ((k < 8) ? 2'b00 : 2'b10)) begin
                failures++; $display("FAIL ps2pl_push_resp[%0d] got=%b exp=%b", k, r, (k < 8) ? 2'b00 : 2'b10);
            end
            if (k == 0) begin
                checks++; if (ps2pl_v !== 1'b1 || ps2pl_data !== 32'hA0) begin failures++; $display("FAIL ps2pl_head_first got=%b/%h exp=1/a0", ps2pl_v, ps2pl_data); end
            end
        end
        axi_read(10'h100, d, r);
        checks++; if (d !== 32'd0 || r !== 2'b00) begin failures++; $display("FAIL ps2pl_free_full got=%0d/%b exp=0/00", d, r); end
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            checks++;
            if (ps2pl_v !== 1'b1 || ps2pl_data !== 32'hA0 + k) begin
                failures++; $display("FAIL ps2pl_drain[%0d] got=%b/%h exp=1/%h", k, ps2pl_v, ps2pl_data, 32'hA0 + k);
            end
            ps2pl_yumi = 1'b1;
            @(posedge aclk); #1;
            ps2pl_yumi = 1'b0;
        end
        @(negedge aclk);
        checks++; if (ps2pl_v !== 1'b0) begin failures++; $display("FAIL ps2pl_drained_v got=%b exp=0", ps2pl_v); end
    endtask

    task automatic test_pl2ps();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] words [2];
        words[0] = 32'h11;
        words[1] = 32'h22;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            checks++; if (pl2ps_ready !== 1'b1) begin failures++; $display("FAIL pl2ps_ready[%0d] got=%b exp=1", k, pl2ps_ready); end
            pl2ps_data = words[k]; pl2ps_v = 1'b1;
            @(posedge aclk); #1;
            pl2ps_v = 1'b0;
        end
        axi_read(10'h300, d, r);
        checks++; if (d !== 32'd2 || r !== 2'b00) begin failures++; $display("FAIL pl2ps_occ got=%0d/%b exp=2/00", d, r); end
        axi_read(10'h200, d, r);
        checks++; if (d !== 32'h11 || r !== 2'b00) begin failures++; $display("FAIL pl2ps_pop0 got=%h/%b exp=11/00", d, r); end
        axi_read(10'h200, d, r);
        checks++; if (d !== 32'h22 || r !== 2'b00) begin failures++; $display("FAIL pl2ps_pop1 got=%h/%b exp=22/00", d, r); end
        axi_read(10'h200, d, r);
        checks++; if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL pl2ps_pop_empty got=%h/%b exp=0/10", d, r); end
    endtask

    task automatic test_errors();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(10'h01C, 32'hFFFFFFFF, 4'b1111, r);
        checks++; if (r !== 2'b11) begin failures++; $display("FAIL decerr_csr_write got=%b exp=11", r); end
        axi_read(10'h000, d, r);
        axi_read(10'h01C, d, r);
        checks++; if (d !== 32'h0 || r !== 2'b11) begin failures++; $display("FAIL decerr_csr_read got=%h/%b exp=0/11", d, r); end
        axi_read(10'h104, d, r);
        checks++; if (r !== 2'b11) begin failures++; $display("FAIL decerr_ps2pl_idx got=%b exp=11", r); end
        axi_write(10'h200, 32'h55, 4'b1111, r);
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL slverr_pop_write got=%b exp=10", r); end
        axi_write(10'h300, 32'h55, 4'b1111, r);
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL slverr_occ_write got=%b exp=10", r); end
        checks++;
        if (csr_data !== {32'h0, 32'h0, 32'h0000BEEF, 32'hAABB5678}) begin
            failures++; $display("FAIL error_csr_unchanged got=%h exp=%h", csr_data, {32'h0, 32'h0, 32'h0000BEEF, 32'hAABB5678});
        end
        axi_read(10'h300, d, r);
        checks++; if (d !== 32'd0 || r !== 2'b00) begin failures++; $display("FAIL error_occ_unchanged got=%0d/%b exp=0/00", d, r); end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq;
        int         n;
        seq = '0;
        n   = 0;
        @(posedge aclk); #1;
        awaddr = 10'h008; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 10'h008; arvalid = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge aclk);
            if (awready) begin seq[n] = 1'b1; n++; end
            else if (arready) begin seq[n] = 1'b0; n++; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        checks++; if (n !== 4) begin failures++; $display("FAIL arb_grant_count got=%0d exp=4", n); end
        checks++; if (seq !== 4'b0101) begin failures++; $display("FAIL arb_order got=%b exp=0101 (bit0 first, 1=write)", seq); end
        checks++; if (csr_data[95:64] !== 32'h5A5A5A5A) begin failures++; $display("FAIL arb_csr2 got=%h exp=5a5a5a5a", csr_data[95:64]); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        ok = 1'b0;
        axi_write(10'h100, 32'hCAFE0001, 4'b1111, r);
        checks++; if (ps2pl_v !== 1'b1) begin failures++; $display("FAIL rst_pre_push_v got=%b exp=1", ps2pl_v); end
        @(posedge aclk); #1;
        bready = 1'b0;
        awaddr = 10'h000; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        checks++; if (!ok || bvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_bvalid got=%b exp=1", bvalid); end
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_bvalid got=%b exp=0", bvalid); end
        checks++; if (csr_data !== 128'h0) begin failures++; $display("FAIL rst_mid_csr got=%h exp=0", csr_data); end
        checks++; if (ps2pl_v !== 1'b0) begin failures++; $display("FAIL rst_mid_ps2pl_v got=%b exp=0", ps2pl_v); end
        checks++; if (pl2ps_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_pl2ps_ready got=%b exp=0", pl2ps_ready); end
        @(posedge aclk); #1;
        areset = 1'b0;
        bready = 1'b1;
        @(negedge aclk);
        checks++; if (pl2ps_ready !== 1'b1 || bvalid !== 1'b0) begin failures++; $display("FAIL rst_release got ready=%b bvalid=%b exp 1 0", pl2ps_ready, bvalid); end
        axi_read(10'h100, d, r);
        checks++; if (d !== 32'd8 || r !== 2'b00) begin failures++; $display("FAIL rst_ps2pl_free got=%0d/%b exp=8/00", d, r); end
    endtask

    initial begin
        test_reset();
        test_csr_strobe();
        test_ps2pl_fill();
        test_pl2ps();
        test_errors();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
